// File: rtl/omr_grading_sequencer_pkg.sv
// omr_grading_sequencer_pkg: shared defaults, state/class enums and key nibble indexing for the OMR grader.
package omr_pkg;
  localparam int DEF_NUM_Q = 10;
  localparam int DEF_OPT_W = 4;
  localparam int DEF_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, GRADE, RESULT} state_t;
  typedef enum logic [1:0] {CLS_BLANK, CLS_CORRECT, CLS_WRONG} cls_t;
  // Q0 sits in the MSB nibble, so question q starts this many bits above bit 0.
  function automatic int key_lsb(input int q, input int num_q, input int opt_w);
    return (num_q - 1 - q) * opt_w;
  endfunction
endpackage

// File: rtl/omr_grading_sequencer_if.sv
// omr_grading_sequencer_if: answer stream and result handshake of the OMR grader.
interface omr_grading_sequencer_if import omr_pkg::*; #(
  parameter int OPT_W = DEF_OPT_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic             ans_valid;
  logic             ans_ready;
  logic [OPT_W-1:0] ans_data;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] score;
  logic             score_neg;
  logic [CNT_W-1:0] correct_cnt;
  logic [CNT_W-1:0] wrong_cnt;
  logic [CNT_W-1:0] blank_cnt;
  modport master(
    output ans_valid, ans_data, res_ready,
    input  ans_ready, res_valid, score, score_neg, correct_cnt, wrong_cnt, blank_cnt
  );
  modport slave(
    input  ans_valid, ans_data, res_ready,
    output ans_ready, res_valid, score, score_neg, correct_cnt, wrong_cnt, blank_cnt
  );
endinterface

// File: rtl/omr_grading_sequencer_classifier.sv
// omr_answer_classifier: classifies one answer nibble as blank, correct or wrong against its key nibble.
module omr_answer_classifier import omr_pkg::*; #(
  parameter int OPT_W = DEF_OPT_W
) (
  input  logic [OPT_W-1:0] ans,
  input  logic [OPT_W-1:0] key,
  output cls_t             cls
);
  // A match only counts when the mark is one-hot, so a malformed key never scores.
  assign cls = ans == '0 ? CLS_BLANK
             : (ans == key && (ans & (ans - 1'b1)) == '0) ? CLS_CORRECT
             : CLS_WRONG;
endmodule

// File: rtl/omr_grading_sequencer.sv
// omr_grading_sequencer: grades a streamed answer sheet against a stored key and presents the net score.
module omr_grading_sequencer import omr_pkg::*; #(
  parameter int NUM_Q = DEF_NUM_Q,
  parameter int OPT_W = DEF_OPT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_load,
  input  logic [NUM_Q*OPT_W-1:0] key_in,
  input  logic                   start,
  input  logic                   abort,
  omr_grading_sequencer_if.slave bus,
  output logic                   key_ok,
  output logic                   busy,
  output logic [7:0]             sheet_cnt
);
  localparam int QW = $clog2(NUM_Q);
  state_t                 state;
  cls_t                   cls;
  logic [NUM_Q*OPT_W-1:0] key;
  logic [QW-1:0]          q_idx;
  logic [OPT_W-1:0]       key_nib;
  logic [CNT_W-1:0]       c_nxt, w_nxt, b_nxt;
  logic                   accept;
  omr_answer_classifier #(.OPT_W(OPT_W)) u_cls (.ans(bus.ans_data), .key(key_nib), .cls(cls));
  always_comb begin
    key_nib = OPT_W'(key >> key_lsb(int'(q_idx), NUM_Q, OPT_W));
    accept  = bus.ans_valid && bus.ans_ready;
    c_nxt   = bus.correct_cnt + CNT_W'(cls == CLS_CORRECT);
    w_nxt   = bus.wrong_cnt + CNT_W'(cls == CLS_WRONG);
    b_nxt   = bus.blank_cnt + CNT_W'(cls == CLS_BLANK);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      key             <= '0;
      q_idx           <= '0;
      key_ok          <= 1'b0;
      busy            <= 1'b0;
      sheet_cnt       <= '0;
      bus.ans_ready   <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.score       <= '0;
      bus.score_neg   <= 1'b0;
      bus.correct_cnt <= '0;
      bus.wrong_cnt   <= '0;
      bus.blank_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            key    <= key_in;
            key_ok <= 1'b1;
          end else if (start && key_ok) begin
            state           <= GRADE;
            busy            <= 1'b1;
            bus.ans_ready   <= 1'b1;
            q_idx           <= '0;
            bus.correct_cnt <= '0;
            bus.wrong_cnt   <= '0;
            bus.blank_cnt   <= '0;
            bus.score       <= '0;
            bus.score_neg   <= 1'b0;
          end
        end
        GRADE: begin
          if (abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            bus.ans_ready <= 1'b0;
          end else if (accept) begin
            bus.correct_cnt <= c_nxt;
            bus.wrong_cnt   <= w_nxt;
            bus.blank_cnt   <= b_nxt;
            bus.score       <= c_nxt >= w_nxt ? c_nxt - w_nxt : '0;
            bus.score_neg   <= w_nxt > c_nxt;
            q_idx           <= q_idx + 1'b1;
            if (q_idx == QW'(NUM_Q - 1)) begin
              state         <= RESULT;
              bus.ans_ready <= 1'b0;
              bus.res_valid <= 1'b1;
            end
          end
        end
        RESULT: begin
          if (abort || bus.res_ready) begin
            state         <= IDLE;
            busy          <= 1'b0;
            bus.res_valid <= 1'b0;
            sheet_cnt     <= abort ? sheet_cnt : sheet_cnt + 8'(sheet_cnt != 8'hff);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_omr_grading_sequencer.sv
// tb_omr_grading_sequencer: randomized sheets graded against a counting reference model.
module tb_omr_grading_sequencer;
  logic        clk = 0;
  logic        reset = 0;
  logic        key_load = 0;
  logic [39:0] key_in = '0;
  logic        start = 0;
  logic        abort = 0;
  logic        key_ok, busy;
  logic [7:0]  sheet_cnt;
  logic [39:0] key_m = '0;
  int          exp_sheet = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  omr_grading_sequencer_if bus ();
  omr_grading_sequencer dut (
    .clk(clk), .reset(reset), .key_load(key_load), .key_in(key_in), .start(start),
    .abort(abort), .bus(bus), .key_ok(key_ok), .busy(busy), .sheet_cnt(sheet_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference grading straight from the rules: count outcomes question by question.
  function automatic void model(input logic [39:0] key, input logic [39:0] ans,
                                output int c, output int w, output int b);
    c = 0; w = 0; b = 0;
    for (int q = 0; q < 10; q++) begin
      logic [3:0] a, k;
      a = ans[(9-q)*4 +: 4];
      k = key[(9-q)*4 +: 4];
      if (a == 0) b++;
      else if (a == k && $countones(k) == 1) c++;
      else w++;
    end
  endfunction

  function automatic logic [3:0] rand_nib;
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return 4'h0;
    if (sel == 3) return 4'($urandom_range(0, 15));
    return 4'(1 << $urandom_range(0, 3));
  endfunction

  function automatic logic [39:0] rand_sheet;
    logic [39:0] s;
    for (int q = 0; q < 10; q++) s[q*4 +: 4] = rand_nib();
    return s;
  endfunction

  task automatic load_key(input logic [39:0] k);
    key_in = k; key_load = 1; tick; key_load = 0;
    key_m = k;
  endtask

  task automatic run_sheet(input logic [39:0] ans, input bit gaps, input bit noise,
                           input int hold, input bit abort_res);
    int c, w, b, sc;
    model(key_m, ans, c, w, b);
    sc = c >= w ? c - w : 0;
    start = 1; tick; start = 0;
    check("busy_grade", busy, 1);
    check("ans_ready_grade", bus.ans_ready, 1);
    for (int q = 0; q < 10; q++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        bus.ans_valid = 0; bus.ans_data = 4'($urandom_range(0, 15));
        start = noise; tick;
      end
      bus.ans_valid = 1; bus.ans_data = ans[(9-q)*4 +: 4];
      if (noise) begin
        start = 1; key_load = 1; key_in = 40'({$urandom(), $urandom()});
      end
      tick;
    end
    start = 0; key_load = 0;
    check("res_valid", bus.res_valid, 1);
    check("correct_cnt", bus.correct_cnt, c);
    check("wrong_cnt", bus.wrong_cnt, w);
    check("blank_cnt", bus.blank_cnt, b);
    check("score", bus.score, sc);
    check("score_neg", bus.score_neg, w > c);
    bus.ans_data = 4'($urandom_range(1, 15));
    for (int i = 0; i < hold; i++) begin
      tick;
      check("hold_ans_ready", bus.ans_ready, 0);
      check("hold_res_valid", bus.res_valid, 1);
      check("hold_score", {bus.score, bus.correct_cnt, bus.wrong_cnt, bus.blank_cnt},
            {4'(sc), 4'(c), 4'(w), 4'(b)});
    end
    bus.ans_valid = 0;
    bus.res_ready = 1; abort = abort_res; tick; bus.res_ready = 0; abort = 0;
    if (!abort_res && exp_sheet < 255) exp_sheet++;
    check("res_valid_drop", bus.res_valid, 0);
    check("busy_idle", busy, 0);
    check("sheet_cnt", sheet_cnt, exp_sheet);
    check("score_idle", bus.score, sc);
  endtask

  initial begin
    bus.ans_valid = 0; bus.ans_data = '0; bus.res_ready = 0;
    repeat (2) tick;
    check("rst_outputs", {bus.ans_ready, bus.res_valid, bus.score_neg, key_ok, busy},
          5'b0);
    check("rst_counts", {bus.score, bus.correct_cnt, bus.wrong_cnt, bus.blank_cnt, sheet_cnt}, 0);
    reset = 1;
    start = 1; tick; start = 0;
    check("start_no_key_busy", busy, 0);

    load_key(40'h1224121888);
    check("key_ok", key_ok, 1);
    check("key_busy", busy, 0);

    run_sheet(40'h1224121888, 0, 0, 0, 0);
    run_sheet(40'h8224244888, 0, 0, 0, 0);
    run_sheet(40'h1224121218, 1, 0, 0, 0);
    run_sheet(40'h8424242212, 0, 0, 2, 0);
    run_sheet(40'h0F24121888, 1, 0, 0, 0);
    run_sheet(rand_sheet(), 1, 1, 5, 0);

    key_in = 40'h8421842184; key_load = 1; start = 1; tick; key_load = 0; start = 0;
    key_m = 40'h8421842184;
    check("load_start_busy", busy, 0);
    run_sheet(40'h8421842184, 0, 0, 0, 0);

    start = 1; tick; start = 0;
    bus.ans_valid = 1;
    for (int q = 0; q < 4; q++) begin bus.ans_data = rand_nib(); tick; end
    abort = 1; tick; abort = 0; bus.ans_valid = 0;
    check("abort_busy", busy, 0);
    check("abort_ans_ready", bus.ans_ready, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_sheet_cnt", sheet_cnt, exp_sheet);
    check("abort_partial", bus.correct_cnt + bus.wrong_cnt + bus.blank_cnt, 4);

    run_sheet(rand_sheet(), 1, 0, 1, 1);

    for (int i = 0; i < 12; i++) begin
      logic [39:0] k;
      k = rand_sheet();
      for (int q = 0; q < 10; q++) if ($urandom_range(0, 3) != 0) k[q*4 +: 4] = 4'(1 << $urandom_range(0, 3));
      load_key(k);
      run_sheet($urandom_range(0, 1) ? k ^ (40'(rand_nib()) << 4 * $urandom_range(0, 9)) : rand_sheet(),
                1, 1, $urandom_range(0, 3), 0);
    end

    while (exp_sheet < 256) begin
      start = 1; tick; start = 0;
      bus.ans_valid = 1; repeat (10) tick; bus.ans_valid = 0;
      bus.res_ready = 1; tick; bus.res_ready = 0;
      exp_sheet++;
    end
    check("sheet_sat", sheet_cnt, 255);

    start = 1; tick; start = 0;
    bus.ans_valid = 1; repeat (3) tick;
    reset = 0; tick; reset = 1; bus.ans_valid = 0;
    check("rst_mid_outputs", {bus.ans_ready, bus.res_valid, bus.score_neg, key_ok, busy},
          5'b0);
    check("rst_mid_counts", {bus.score, bus.correct_cnt, bus.wrong_cnt, bus.blank_cnt, sheet_cnt}, 0);
    start = 1; tick; start = 0;
    check("start_after_rst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/omr_grading_sequencer.md
Name: omr_grading_sequencer

Overview:
- Sequential grading controller for the OMR datapath.
- Holds a registered answer key and accepts one student sheet as a stream of per-question answer nibbles over a valid/ready handshake.
- Classifies each answer as correct, wrong or blank, and accumulates counts.
- Presents a net score (correct minus wrong, clamped at 0) plus a negative flag through a result handshake. Sits between the scanner front-end and the result/report logic.

Parameters:
- NUM_Q, 10, questions per sheet.
- OPT_W, 4, options per question; one-hot answer encoding.
- CNT_W, 4, width of score and counters; must be at least clog2(NUM_Q+1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; 0 resets the block.
- key_load  in  1  one-cycle pulse: latch key_in as the answer key.
- key_in  in  NUM_Q*OPT_W  answer key; Q0 is in the MSB nibble, Q(NUM_Q-1) in the LSB nibble.
- start  in  1  begin grading a sheet.
- abort  in  1  cancel the sheet in progress.
- ans_valid  in  1  ans_data is valid.
- ans_ready  out  1  sequencer accepts an answer this cycle.
- ans_data  in  OPT_W  the student's marks for the current question.
- res_valid  out  1  result outputs are valid.
- res_ready  in  1  consumer takes the result.
- score  out  CNT_W  net score: max(0, correct - wrong).
- score_neg  out  1  1 when wrong > correct.
- correct_cnt  out  CNT_W  number of correct answers.
- wrong_cnt  out  CNT_W  number of wrong answers.
- blank_cnt  out  CNT_W  number of blank answers.
- key_ok  out  1  a key has been loaded since reset.
- busy  out  1  state is not IDLE.
- sheet_cnt  out  8  sheets completed; saturates at 255.

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: ans_ready, res_valid, score, score_neg, all counters, key_ok, busy, sheet_cnt.
  - The key register is cleared.
  - Reset mid-sheet discards all partial counts.
- FSM states: IDLE, GRADE, RESULT.
- IDLE:
  - key_load=1 latches key_in and sets key_ok=1.
  - If key_load=1, start is ignored that cycle (key_load has priority).
  - start=1 with key_ok=1 and key_load=0 goes to GRADE next cycle. On that transition, q_idx and all counters clear.
  - start=1 with key_ok=0 is ignored.
- GRADE:
  - ans_ready=1. An answer is accepted on any cycle with ans_valid=1 (ans_valid & ans_ready).
  - Each accepted answer is classified against key nibble q_idx and the matching counter is incremented:
    - blank if ans_data == 0;
    - correct if ans_data == key nibble exactly;
    - otherwise wrong, which includes multi-marked answers and a single mark on the wrong option.
  - Then q_idx increments.
  - When the answer for q_idx == NUM_Q-1 is accepted, go to RESULT. res_valid rises the next cycle (1-cycle latency), with the final counts visible.
  - key_load and start are ignored in GRADE.
- RESULT:
  - ans_ready=0. res_valid=1.
  - score = correct_cnt - wrong_cnt if correct_cnt >= wrong_cnt, else 0.
  - score_neg = (wrong_cnt > correct_cnt).
  - All result outputs are registered and held stable until res_ready=1.
  - On res_valid & res_ready: go to IDLE, res_valid drops next cycle, sheet_cnt increments (saturating at 255).
  - Counts and score remain readable in IDLE until the next start.
- abort=1 in GRADE or RESULT:
  - Next state is IDLE, res_valid=0, sheet_cnt is unchanged. Counts may hold partial values.
  - abort overrides a simultaneous answer handshake or result handshake.
- Keys are not validated for one-hot form. A non-one-hot key nibble can never yield a correct answer.
- busy = (state != IDLE).

Decomposition:
- Package omr_pkg:
  - NUM_Q and OPT_W defaults.
  - state enum {IDLE, GRADE, RESULT}.
  - answer class enum {CLS_BLANK, CLS_CORRECT, CLS_WRONG}.
  - Key nibble index function.
- Sub-module omr_answer_classifier: combinational; inputs ans, key; output class.
- The sequencer holds the FSM, counters and score arithmetic.

Test Plan:
- Reset and key load:
  - Reset low for 2 cycles -> all outputs 0.
  - key_load with key_in = 0x1224121888 -> key_ok=1, busy=0.
- Perfect sheet:
  - start, then 10 answers equal to the key nibbles, ans_valid held high continuously -> res_valid 1 cycle after the 10th accept.
  - score=10, correct_cnt=10, wrong_cnt=0, score_neg=0. sheet_cnt=1 after res_ready.
- Mixed sheet:
  - Answers 0x8224244888 -> correct_cnt=6, wrong_cnt=4, score=2, score_neg=0.
  - Answers 0x1224121218 -> correct_cnt=8, wrong_cnt=2, score=6.
- Negative and blank handling:
  - Answers 0x8424242212 -> correct_cnt=2, wrong_cnt=8, score=0, score_neg=1.
  - Answers 0x0F24121888 (Q0 blank, Q1 multi-mark) -> blank_cnt=1, wrong_cnt=1, correct_cnt=8, score=7.
- Handshake stress:
  - Random ans_valid gaps; res_ready held low 5 cycles -> outputs stable, no extra answers accepted (ans_ready=0).
  - start during GRADE is ignored.
  - key_load and start in the same IDLE cycle -> key updated, state stays IDLE.
- Abort and reset mid-sheet:
  - abort after 4 answers -> IDLE next cycle, sheet_cnt unchanged.
  - reset=0 during GRADE -> all outputs 0, key_ok=0.
  - start with key_ok=0 -> busy stays 0.
